// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage, producer side of the IF->ID register.
//
// Holds the PC and looks it up in a direct-mapped, one-word-per-line
// instruction cache. On a miss, the word is fetched from the memory controller
// through a req/done handshake. Each fetched instruction reaches IF/ID as a
// one-cycle instE/pc/inst pulse. The stage honours IF stall, jump redirects
// and cancellation of an in-flight fetch.
//
// Ports:
//   clk_in, rst_in         clock; synchronous active-high reset
//   stall_in[5:0]          stall vector; only bit 0 (IF stalled) is used here
//   pcJump_in/pcTarget_in  redirect from EX; target bits [1:0] are forced to 0
//   memReq_out/memAddr_out fetch request; held until memDone_in
//   memDone_in/memInst_in  one-cycle completion pulse with the fetched word
//   instE_out/pc_out/inst_out  registered delivery pulse to IF/ID
//   stallReq_out           high while a miss is outstanding (WAIT or FLUSH)
module if_fetch #(
  parameter int unsigned INDEX_BITS = 7,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [5:0]  stall_in,
  input  logic        pcJump_in,
  input  logic [31:0] pcTarget_in,
  output logic        memReq_out,
  output logic [31:0] memAddr_out,
  input  logic        memDone_in,
  input  logic [31:0] memInst_in,
  output logic        instE_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        stallReq_out
);
  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH, S_HOLD} state_t;

  function automatic logic [INDEX_BITS-1:0] idx_of(input logic [31:0] a);
    return a[INDEX_BITS+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return a[31:INDEX_BITS+2];
  endfunction

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                inst_e_q, inst_e_d;
  logic [31:0]         pc_out_q, pc_out_d;
  logic [31:0]         inst_out_q, inst_out_d;
  logic                stall_req_q, stall_req_d;
  logic [31:0]         hold_addr_q, hold_addr_d;
  logic [31:0]         hold_inst_q, hold_inst_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]    tag_mem_q  [ENTRIES];
  logic [31:0]         data_mem_q [ENTRIES];

  logic                  fill_en;
  logic [INDEX_BITS-1:0] look_idx, fill_idx;
  logic [TAG_W-1:0]      look_tag, fill_tag;
  logic                  hit;
  logic [31:0]           jump_pc, pc_inc;
  logic                  unused_bits;

  // Lookup: index/tag of the current PC against the cache arrays.
  assign look_idx = idx_of(pc_q);
  assign look_tag = tag_of(pc_q);
  assign hit      = valid_q[look_idx] && (tag_mem_q[look_idx] == look_tag);

  // Fills always land at the latched request address, not the (possibly
  // redirected) PC.
  assign fill_idx = idx_of(mem_addr_q);
  assign fill_tag = tag_of(mem_addr_q);

  assign jump_pc     = {pcTarget_in[31:2], 2'b00};
  assign pc_inc      = pc_q + 32'd4;
  assign unused_bits = ^{stall_in[5:1], pcTarget_in[1:0]};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    inst_e_d    = 1'b0;
    pc_out_d    = pc_out_q;
    inst_out_d  = inst_out_q;
    hold_addr_d = hold_addr_q;
    hold_inst_d = hold_inst_q;
    valid_d     = valid_q;
    fill_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pcJump_in) begin
          pc_d = jump_pc;
        end else if (!stall_in[0]) begin
          if (hit) begin
            inst_e_d   = 1'b1;
            pc_out_d   = pc_q;
            inst_out_d = data_mem_q[look_idx];
            pc_d       = pc_inc;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (memDone_in) begin
          // A jump arriving with the data still lets the fill complete, but
          // the word belongs to the abandoned path and is dropped.
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          if (pcJump_in) begin
            pc_d = jump_pc;
          end else begin
            pc_d = pc_inc;
            if (!stall_in[0]) begin
              inst_e_d   = 1'b1;
              pc_out_d   = mem_addr_q;
              inst_out_d = memInst_in;
            end else begin
              hold_addr_d = mem_addr_q;
              hold_inst_d = memInst_in;
              state_d     = S_HOLD;
            end
          end
        end else if (pcJump_in) begin
          // The controller cannot abort, so keep requesting and discard later.
          pc_d    = jump_pc;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pcJump_in) begin
          pc_d = jump_pc;
        end
        if (memDone_in) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_HOLD: begin
        if (pcJump_in) begin
          pc_d    = jump_pc;
          state_d = S_IDLE;
        end else if (!stall_in[0]) begin
          inst_e_d   = 1'b1;
          pc_out_d   = hold_addr_q;
          inst_out_d = hold_inst_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
    end
    stall_req_d = (state_d == S_WAIT) || (state_d == S_FLUSH);
  end

  // Register boundary: control, outputs and hold buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      inst_e_q    <= 1'b0;
      pc_out_q    <= '0;
      inst_out_q  <= '0;
      stall_req_q <= 1'b0;
      hold_addr_q <= '0;
      hold_inst_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      inst_e_q    <= inst_e_d;
      pc_out_q    <= pc_out_d;
      inst_out_q  <= inst_out_d;
      stall_req_q <= stall_req_d;
      hold_addr_q <= hold_addr_d;
      hold_inst_q <= hold_inst_d;
      valid_q     <= valid_d;
    end
  end

  // Register boundary: cache tag/data arrays (validity lives in valid_q).
  always_ff @(posedge clk_in) begin
    if (!rst_in && fill_en) begin
      tag_mem_q[fill_idx]  <= fill_tag;
      data_mem_q[fill_idx] <= memInst_in;
    end
  end

  assign memReq_out   = mem_req_q;
  assign memAddr_out  = mem_addr_q;
  assign instE_out    = inst_e_q;
  assign pc_out       = pc_out_q;
  assign inst_out     = inst_out_q;
  assign stallReq_out = stall_req_q;
endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  logic        clk_in;
  logic        rst_in;
  logic [5:0]  stall_in;
  logic        pcJump_in;
  logic [31:0] pcTarget_in;
  logic        memReq_out;
  logic [31:0] memAddr_out;
  logic        memDone_in;
  logic [31:0] memInst_in;
  logic        instE_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        stallReq_out;

  int checks = 0;
  int errors = 0;

  if_fetch #(.INDEX_BITS(7), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
    .pcJump_in(pcJump_in), .pcTarget_in(pcTarget_in),
    .memReq_out(memReq_out), .memAddr_out(memAddr_out),
    .memDone_in(memDone_in), .memInst_in(memInst_in),
    .instE_out(instE_out), .pc_out(pc_out), .inst_out(inst_out),
    .stallReq_out(stallReq_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cache held as full word addresses per line; fetch progress kept as
  // flags (outstanding fetch, result discarded, instruction held).
  bit          mc_valid [128];
  logic [31:0] mc_addr  [128];
  logic [31:0] mc_inst  [128];
  bit          m_init = 0;
  logic [31:0] m_pc, m_paddr, m_haddr, m_hinst;
  bit          m_pending, m_discard, m_held;
  logic        e_req, e_inste, e_stallreq;
  logic [31:0] e_addr, e_pc, e_inst;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd128);
  endfunction

  always @(posedge clk_in) begin : model
    logic [31:0] tgt;
    int          li;
    tgt = pcTarget_in & 32'hFFFF_FFFC;
    e_inste = 1'b0;
    if (rst_in) begin
      m_init = 1; m_pc = 32'h0;
      m_pending = 0; m_discard = 0; m_held = 0;
      e_req = 0; e_addr = 0; e_pc = 0; e_inst = 0;
      for (int i = 0; i < 128; i++) mc_valid[i] = 0;
    end else if (m_init) begin
      if (m_held) begin
        if (pcJump_in) begin
          m_held = 0; m_pc = tgt;
        end else if (!stall_in[0]) begin
          m_held = 0; e_inste = 1; e_pc = m_haddr; e_inst = m_hinst;
        end
      end else if (m_pending) begin
        if (memDone_in) begin
          li = line_of(m_paddr);
          mc_valid[li] = 1; mc_addr[li] = m_paddr; mc_inst[li] = memInst_in;
          e_req = 0; m_pending = 0;
          if (m_discard || pcJump_in) begin
            if (pcJump_in) m_pc = tgt;
          end else begin
            m_pc = m_pc + 32'd4;
            if (!stall_in[0]) begin
              e_inste = 1; e_pc = m_paddr; e_inst = memInst_in;
            end else begin
              m_held = 1; m_haddr = m_paddr; m_hinst = memInst_in;
            end
          end
          m_discard = 0;
        end else if (pcJump_in) begin
          m_pc = tgt; m_discard = 1;
        end
      end else begin
        li = line_of(m_pc);
        if (pcJump_in) begin
          m_pc = tgt;
        end else if (!stall_in[0]) begin
          if (mc_valid[li] && mc_addr[li] == m_pc) begin
            e_inste = 1; e_pc = m_pc; e_inst = mc_inst[li];
            m_pc = m_pc + 32'd4;
          end else begin
            m_pending = 1; m_paddr = m_pc; e_req = 1; e_addr = m_pc;
          end
        end
      end
    end
    e_stallreq = m_pending;
  end

  always @(negedge clk_in) begin
    if (m_init) begin
      chk("m_memReq",   {31'b0, memReq_out},   {31'b0, e_req});
      chk("m_memAddr",  memAddr_out,           e_addr);
      chk("m_instE",    {31'b0, instE_out},    {31'b0, e_inste});
      chk("m_pc_out",   pc_out,                e_pc);
      chk("m_inst_out", inst_out,              e_inst);
      chk("m_stallReq", {31'b0, stallReq_out}, {31'b0, e_stallreq});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
    pcJump_in  = 1'b0;
    memDone_in = 1'b0;
  endtask

  task automatic emit_chk(input string name, input logic [31:0] pc, input logic [31:0] inst);
    chk({name, "_instE"}, {31'b0, instE_out}, 32'd1);
    chk({name, "_pc"}, pc_out, pc);
    chk({name, "_inst"}, inst_out, inst);
  endtask

  task automatic req_chk(input string name, input logic [31:0] addr);
    chk({name, "_req"}, {31'b0, memReq_out}, 32'd1);
    chk({name, "_addr"}, memAddr_out, addr);
    chk({name, "_stallReq"}, {31'b0, stallReq_out}, 32'd1);
  endtask

  task automatic serve(input logic [31:0] inst);
    memInst_in = inst;
    memDone_in = 1'b1;
    tick();
  endtask

  task automatic jump(input logic [31:0] tgt);
    pcTarget_in = tgt;
    pcJump_in   = 1'b1;
    tick();
  endtask

  logic [31:0] stream_inst [4];

  initial begin
    rst_in = 1'b1; stall_in = '0; pcJump_in = 1'b0; pcTarget_in = '0;
    memDone_in = 1'b0; memInst_in = '0;
    stream_inst[0] = 32'h0000_0013; stream_inst[1] = 32'h0040_0093;
    stream_inst[2] = 32'h0080_0113; stream_inst[3] = 32'h00C0_0193;
    tick(); tick();
    chk("rst_memReq", {31'b0, memReq_out}, 32'd0);
    chk("rst_instE", {31'b0, instE_out}, 32'd0);
    chk("rst_stallReq", {31'b0, stallReq_out}, 32'd0);
    chk("rst_memAddr", memAddr_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_inst_out", inst_out, 32'h0);

    // Cold start and fill 0x0..0xC through misses.
    rst_in = 1'b0;
    tick();
    req_chk("cold0", 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        req_chk("cold_next", 32'(k * 4));
      end
      serve(stream_inst[k]);
      emit_chk("cold_emit", 32'(k * 4), stream_inst[k]);
      chk("cold_stallReq_drop", {31'b0, stallReq_out}, 32'd0);
    end

    // Hit streaming.
    jump(32'h0);
    chk("jmp_noemit", {31'b0, instE_out}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      emit_chk("hit", 32'(k * 4), stream_inst[k]);
      chk("hit_noreq", {31'b0, memReq_out}, 32'd0);
    end

    // Jump during miss, then a second jump while flushing.
    tick();
    req_chk("miss10", 32'h10);
    jump(32'h80);
    req_chk("flush1", 32'h10);
    jump(32'h40);
    req_chk("flush2", 32'h10);
    tick();
    serve(32'h1234_5678);
    chk("flush_noemit", {31'b0, instE_out}, 32'd0);
    chk("flush_reqdrop", {31'b0, memReq_out}, 32'd0);
    chk("flush_stallReq", {31'b0, stallReq_out}, 32'd0);
    tick();
    req_chk("miss40", 32'h40);
    serve(32'h0400_0513);
    emit_chk("emit40", 32'h40, 32'h0400_0513);
    jump(32'h10);
    tick();
    emit_chk("hit10", 32'h10, 32'h1234_5678);
    chk("hit10_noreq", {31'b0, memReq_out}, 32'd0);

    // Stall when the fetch completes.
    jump(32'h20);
    tick();
    req_chk("miss20", 32'h20);
    stall_in = 6'b000001;
    serve(32'hDEAD_BEEF);
    chk("hold_reqdrop", {31'b0, memReq_out}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_quiet", {31'b0, instE_out}, 32'd0);
      tick();
    end
    chk("hold_quiet", {31'b0, instE_out}, 32'd0);
    stall_in = 6'b0;
    tick();
    emit_chk("hold_emit", 32'h20, 32'hDEAD_BEEF);
    tick();
    chk("hold_single", {31'b0, instE_out}, 32'd0);
    req_chk("miss24", 32'h24);

    // Jump and done on the same edge; misaligned target.
    pcTarget_in = 32'h43; pcJump_in = 1'b1;
    serve(32'h0244_0A13);
    chk("jd_noemit", {31'b0, instE_out}, 32'd0);
    chk("jd_reqdrop", {31'b0, memReq_out}, 32'd0);
    tick();
    emit_chk("jd_hit40", 32'h40, 32'h0400_0513);
    tick();
    req_chk("miss44", 32'h44);

    // Jump while holding discards the held word.
    stall_in = 6'b000001;
    serve(32'h0444_0B13);
    chk("hj_quiet", {31'b0, instE_out}, 32'd0);
    jump(32'h24);
    chk("hj_noemit", {31'b0, instE_out}, 32'd0);
    stall_in = 6'b0;
    tick();
    emit_chk("hj_hit24", 32'h24, 32'h0244_0A13);

    // Reset mid-miss; late done ignored; cache invalidated.
    tick();
    req_chk("miss28", 32'h28);
    rst_in = 1'b1;
    tick();
    chk("rmid_req", {31'b0, memReq_out}, 32'd0);
    chk("rmid_stallReq", {31'b0, stallReq_out}, 32'd0);
    chk("rmid_pc_out", pc_out, 32'h0);
    chk("rmid_inst_out", inst_out, 32'h0);
    rst_in = 1'b0;
    serve(32'h0BAD_0BAD);
    chk("late_noemit", {31'b0, instE_out}, 32'd0);
    req_chk("restart0", 32'h0);
    serve(32'h0000_0013);
    emit_chk("restart_emit", 32'h0, 32'h13);

    // PC wrap-around.
    jump(32'hFFFF_FFFD);
    tick();
    req_chk("missFFFC", 32'hFFFF_FFFC);
    serve(32'hFFFF_0013);
    emit_chk("emitFFFC", 32'hFFFF_FFFC, 32'hFFFF_0013);
    tick();
    emit_chk("wrap_hit0", 32'h0, 32'h13);
    tick();
    req_chk("wrap_miss4", 32'h4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage and producer side of the IF→ID pipeline-register interface.
- Holds the PC and looks up a direct-mapped instruction cache.
- On a miss, fetches the 32-bit instruction from the memory controller through a req/done handshake.
- Presents each fetched instruction to IF/ID as a one-cycle instE/pc/inst pulse, and honours stall, jump redirect and in-flight fetch cancellation.

Parameters:
- INDEX_BITS, 7, cache index width; 2^INDEX_BITS entries of one instruction each.
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  synchronous reset, active-high.
- stall_in  input  6  stall vector; bit 0 = IF stalled.
- pcJump_in  input  1  redirect request from EX, sampled at posedge.
- pcTarget_in  input  32  redirect target; bits [1:0] ignored (forced 0).
- memReq_out  output  1  fetch request to memory controller; held until memDone_in.
- memAddr_out  output  32  word-aligned fetch address; stable while memReq_out=1.
- memDone_in  input  1  one-cycle pulse: memInst_in is valid.
- memInst_in  input  32  fetched instruction.
- instE_out  output  1  one-cycle pulse: pc_out/inst_out form a valid instruction for IF/ID.
- pc_out  output  32  address of the delivered instruction.
- inst_out  output  32  delivered instruction.
- stallReq_out  output  1  high while a miss is outstanding (states WAIT and FLUSH).

Behaviour:
- Reset (rst_in=1 at posedge, any state):
  - pc ← RESET_PC; state ← IDLE; all valid bits ← 0.
  - memReq_out, instE_out, stallReq_out ← 0; memAddr_out, pc_out, inst_out ← 0; hold buffer cleared.
  - A memDone_in arriving after reset, with state not WAIT/FLUSH, is ignored.
- Cache:
  - index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
  - Hit = valid[index] and tag match.
  - Written only on memDone_in in WAIT or FLUSH, at the latched request address. The write overwrites the line.
- All outputs are registered. instE_out is never high for two consecutive cycles with the same pc_out.
- Priority each posedge: reset > pcJump_in > memDone_in > stall > new lookup.
- IDLE:
  - pcJump_in=1: pc ← target; instE_out ← 0; stay IDLE.
  - Otherwise, stall_in[0]=1: instE_out ← 0; no lookup.
  - Otherwise, hit: instE_out ← 1, pc_out ← pc, inst_out ← cached word, pc ← pc+4. Latency: one instruction per cycle on consecutive hits.
  - Otherwise, miss: memReq_out ← 1, memAddr_out ← pc, state ← WAIT.
- WAIT:
  - memReq_out stays 1; stallReq_out=1.
  - pcJump_in=1: pc ← target; state ← FLUSH; request stays up because the controller cannot abort.
  - memDone_in=1 (no jump): fill cache; memReq_out ← 0; pc ← pc+4.
    - If stall_in[0]=0: emit the instruction (instE_out=1 next cycle); state ← IDLE.
    - Else: store {addr, inst} in the hold buffer; state ← HOLD.
- FLUSH:
  - Wait for memDone_in, then fill cache, drop memReq_out and go to IDLE. The instruction is not emitted.
  - Further jumps only update pc.
  - Simultaneous jump+done: cache filled, data discarded, pc ← new target, state ← IDLE.
- HOLD:
  - instE_out=0 while stall_in[0]=1.
  - First cycle with stall_in[0]=0: emit the held instruction; state ← IDLE.
  - pcJump_in=1: discard the held instruction, pc ← target, state ← IDLE.
- PC arithmetic is 32-bit with wrap-around: 32'hFFFF_FFFC+4 = 0.

Test Plan:
- Reset then cold start, RESET_PC=0:
  - memReq_out=1, memAddr_out=0 one cycle after reset release.
  - memDone_in with 32'h00000013 → instE_out pulse with pc_out=0, inst_out=32'h13.
  - Next request to 0x4; stallReq_out high only during the miss.
- Hit streaming: preload 0x0–0xC via misses, jump to 0 → four consecutive instE_out pulses, pc_out 0,4,8,C, no memReq_out.
- Jump during miss: miss at 0x10 outstanding, pcJump_in with target 0x40.
  - memDone_in for 0x10 produces no instE_out; memReq_out drops.
  - The next request is 0x40.
  - A later jump to 0x10 hits, with no memReq_out.
- Stall on done: stall_in[0]=1 when memDone_in arrives for 0x20 with 32'hDEADBEEF.
  - instE_out stays 0 for three stall cycles.
  - A single pulse with pc_out=0x20 appears the cycle after stall drops.
- Simultaneous jump+done in WAIT, and jump in HOLD → no emission, pc = target, state IDLE. Target 32'h00000043 fetches 0x40.
- Reset mid-miss: rst_in asserted in WAIT → memReq_out=0 next cycle, valid bits cleared, the late memDone_in is ignored, and the fetch restarts at RESET_PC.
